// File: rtl/buffer_ctrl_pkg.sv
// buffer_ctrl_pkg: shared types, default geometry and helpers for the input buffer sequencer
package buffer_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam int DW = 4;
  localparam int DOS = 4;
  localparam int INS = 4;
  localparam int OUTS = 3;
  localparam int CW = 16;
  localparam int WORD_W = INS * DOS * DW;
  function automatic int unsigned popcount(input logic [OUTS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < OUTS; i++) n = n + 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/buffer_idle_timer.sv
// buffer_idle_timer: counts consecutive idle cycles and flags the one that reaches TIMEOUT
module buffer_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + TW'(1);
  // combinational so the FSM leaves on the edge that completes the TIMEOUT-th idle cycle
  assign expired = en && (cnt == TW'(TIMEOUT - 1));
endmodule

// File: rtl/buffer_load_ctrl.sv
// buffer_load_ctrl: handshakes input words into the convolution buffer and tracks job completion
module buffer_load_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DW,
  parameter int DATA_OF_SET = DOS,
  parameter int IN_NUM_OF_SET = INS,
  parameter int OUT_NUM_OF_SET = OUTS,
  parameter int CNT_WIDTH = CW,
  parameter int TIMEOUT = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [CNT_WIDTH-1:0]                           cfg_in_words,
  input  logic [CNT_WIDTH-1:0]                           cfg_out_sets,
  input  logic                                           s_valid,
  output logic                                           s_ready,
  input  logic [IN_NUM_OF_SET*DATA_OF_SET*DATA_WIDTH-1:0] s_data,
  output logic                                           buf_wen,
  output logic [IN_NUM_OF_SET*DATA_OF_SET*DATA_WIDTH-1:0] buf_din,
  input  logic                                           buf_full,
  input  logic [OUT_NUM_OF_SET-1:0]                      buf_valid,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           err_timeout,
  output logic [CNT_WIDTH-1:0]                           in_cnt,
  output logic [CNT_WIDTH-1:0]                           out_cnt
);
  state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] cfg_in, cfg_out, out_nxt;
  logic [CNT_WIDTH:0] out_sum;
  logic load, drain, in_end, out_end, expired;
  assign load = state == LOAD;
  assign drain = state == DRAIN;
  assign out_sum = {1'b0, out_cnt} + (CNT_WIDTH + 1)'(popcount(buf_valid));
  assign out_nxt = out_sum[CNT_WIDTH] ? '1 : out_sum[CNT_WIDTH-1:0];
  assign in_end = (in_cnt == cfg_in) || (buf_wen && (in_cnt + CNT_WIDTH'(1) == cfg_in));
  assign out_end = out_nxt >= cfg_out;
  buffer_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!drain || (|buf_valid)),
    .en(drain && !(|buf_valid)),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = start ? LOAD : IDLE;
      LOAD:  state_nxt = in_end ? DRAIN : LOAD;
      DRAIN: state_nxt = (out_end || expired) ? DONE : DRAIN;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s_ready = load && !buf_full && (in_cnt != cfg_in);
    buf_wen = s_valid && s_ready;
    buf_din = load ? s_data : '0;
    busy = load || drain;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg_in <= '0;
      cfg_out <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      err_timeout <= 1'b0;
    end else if (state == IDLE && start) begin
      cfg_in <= cfg_in_words;
      cfg_out <= cfg_out_sets;
      in_cnt <= '0;
      out_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (buf_wen) in_cnt <= in_cnt + CNT_WIDTH'(1);
      if (load || drain) out_cnt <= out_nxt;
      if (expired) err_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_buffer_load_ctrl.sv
// tb_buffer_load_ctrl: directed checks of handshake, counting, timeout and reset behaviour
module tb_buffer_load_ctrl;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, buf_full = 0;
  logic [15:0] cfg_in_words = 0, cfg_out_sets = 0;
  logic [63:0] s_data = 0;
  logic [2:0] buf_valid = 0;
  logic s_ready, buf_wen, busy, done, err_timeout;
  logic [63:0] buf_din;
  logic [15:0] in_cnt, out_cnt;
  int tests = 0, fails = 0;

  buffer_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_words(cfg_in_words),
    .cfg_out_sets(cfg_out_sets), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .buf_wen(buf_wen), .buf_din(buf_din), .buf_full(buf_full),
    .buf_valid(buf_valid), .busy(busy), .done(done), .err_timeout(err_timeout),
    .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nxt; nxt;
    chk("rst_ready", s_ready, 0); chk("rst_wen", buf_wen, 0); chk("rst_din", buf_din, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err_timeout, 0);
    chk("rst_in", in_cnt, 0); chk("rst_out", out_cnt, 0);
    rst = 0;
    // basic job: 3 words, 12 sets in groups of 3
    cfg_in_words = 3; cfg_out_sets = 12; start = 1;
    nxt;
    start = 0; s_valid = 1; s_data = 64'h1111_2222_3333_4444; #1;
    chk("t1_busy", busy, 1); chk("t1_ready0", s_ready, 1); chk("t1_wen0", buf_wen, 1);
    chk("t1_din", buf_din, 64'h1111_2222_3333_4444); chk("t1_in0", in_cnt, 0);
    nxt; s_data = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    chk("t1_in1", in_cnt, 1); chk("t1_wen1", buf_wen, 1); chk("t1_din1", buf_din, 64'hAAAA_BBBB_CCCC_DDDD);
    nxt;
    chk("t1_in2", in_cnt, 2); chk("t1_ready2", s_ready, 1); chk("t1_wen2", buf_wen, 1);
    nxt;
    chk("t1_in3", in_cnt, 3); chk("t1_drain_ready", s_ready, 0); chk("t1_drain_wen", buf_wen, 0);
    chk("t1_drain_busy", busy, 1);
    buf_valid = 3'b111;
    nxt; nxt; nxt;
    chk("t1_out9", out_cnt, 9); chk("t1_busy9", busy, 1);
    nxt;
    buf_valid = 0; s_valid = 0; #1;
    chk("t1_done", done, 1); chk("t1_out12", out_cnt, 12); chk("t1_err", err_timeout, 0);
    chk("t1_busy_done", busy, 0);
    nxt;
    chk("t1_done_clr", done, 0); chk("t1_hold_in", in_cnt, 3); chk("t1_hold_out", out_cnt, 12);
    // buf_full stalls in LOAD cycles 2-4
    cfg_in_words = 3; cfg_out_sets = 0; start = 1;
    nxt;
    start = 0; s_valid = 1; #1;
    chk("t2_wen1", buf_wen, 1); chk("t2_out_clr", out_cnt, 0);
    nxt; buf_full = 1; #1;
    chk("t2_full_ready", s_ready, 0); chk("t2_full_wen", buf_wen, 0);
    nxt; nxt;
    chk("t2_full_wen4", buf_wen, 0); chk("t2_stall_in", in_cnt, 1);
    nxt; buf_full = 0; #1;
    chk("t2_resume_wen", buf_wen, 1);
    nxt;
    chk("t2_in2", in_cnt, 2);
    nxt;
    chk("t2_in3", in_cnt, 3); chk("t2_drain_ready", s_ready, 0);
    nxt;
    s_valid = 0; #1;
    chk("t2_done", done, 1);
    nxt;
    // drain timeout after 9 of 12 sets
    cfg_in_words = 0; cfg_out_sets = 12; start = 1;
    nxt;
    start = 0; s_valid = 1; #1;
    chk("t3_load_ready", s_ready, 0); chk("t3_load_wen", buf_wen, 0); chk("t3_busy", busy, 1);
    nxt;
    s_valid = 0; buf_valid = 3'b111;
    nxt; nxt; nxt;
    buf_valid = 0; #1;
    chk("t3_out9", out_cnt, 9);
    for (int i = 0; i < 63; i++) nxt;
    chk("t3_still_drain", busy, 1); chk("t3_no_err_yet", err_timeout, 0);
    nxt;
    chk("t3_done", done, 1); chk("t3_err", err_timeout, 1); chk("t3_out_hold", out_cnt, 9);
    nxt;
    chk("t3_err_sticky", err_timeout, 1);
    // zero-length job clears err and completes in LOAD, DRAIN, DONE
    cfg_in_words = 0; cfg_out_sets = 0; start = 1;
    nxt;
    start = 0; s_valid = 1; #1;
    chk("t4_err_clr", err_timeout, 0); chk("t4_load_ready", s_ready, 0); chk("t4_load_wen", buf_wen, 0);
    chk("t4_load_busy", busy, 1);
    nxt;
    chk("t4_drain_busy", busy, 1); chk("t4_drain_done", done, 0); chk("t4_drain_wen", buf_wen, 0);
    nxt;
    chk("t4_done", done, 1); chk("t4_in0", in_cnt, 0);
    nxt;
    s_valid = 0;
    // reset in LOAD with two words written
    cfg_in_words = 3; cfg_out_sets = 3; start = 1;
    nxt;
    start = 0; s_valid = 1;
    nxt; nxt;
    chk("t5_in2", in_cnt, 2);
    rst = 1; #1;
    chk("t5_rst_busy", busy, 0); chk("t5_rst_in", in_cnt, 0); chk("t5_rst_ready", s_ready, 0);
    chk("t5_rst_wen", buf_wen, 0);
    nxt;
    rst = 0; cfg_in_words = 1; cfg_out_sets = 3; start = 1;
    nxt;
    start = 0; #1;
    chk("t5_fresh_wen", buf_wen, 1);
    nxt;
    s_valid = 0; buf_valid = 3'b111;
    nxt;
    buf_valid = 0; #1;
    chk("t5_fresh_done", done, 1); chk("t5_fresh_in", in_cnt, 1); chk("t5_fresh_out", out_cnt, 3);
    nxt;
    // start ignored in LOAD, DRAIN and DONE; counting active in LOAD
    cfg_in_words = 2; cfg_out_sets = 3; start = 1;
    nxt;
    cfg_in_words = 5; cfg_out_sets = 100; s_valid = 1; buf_valid = 3'b011;
    nxt;
    buf_valid = 0; #1;
    chk("t6_in1", in_cnt, 1); chk("t6_out_load", out_cnt, 2);
    nxt;
    s_valid = 0; buf_valid = 3'b001; #1;
    chk("t6_in2", in_cnt, 2); chk("t6_drain_ready", s_ready, 0);
    nxt;
    buf_valid = 0; #1;
    chk("t6_done", done, 1); chk("t6_out3", out_cnt, 3); chk("t6_in_hold", in_cnt, 2);
    nxt;
    chk("t6_idle_after_done", busy, 0);
    start = 0;
    nxt;
    chk("t6_still_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
